// File: rtl/spm_serial_ctrl.sv
// Sequencer around the spm carry-save array: loads x in parallel, streams y LSB-first
// (sign- or zero-extended), and deserialises the serial product into a 2*WIDTH-bit result.
module spm_serial_ctrl #(
  parameter int WIDTH   = 32,
  parameter bit SIGNED  = 1'b1,
  parameter int ARR_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  output logic [WIDTH-1:0]     arr_x,
  output logic                 arr_clr,
  output logic                 y_ser,
  input  logic                 p_ser,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW + ARR_LAT + 1);
  localparam logic [CW-1:0] W_CNT    = CW'(WIDTH);
  localparam logic [CW-1:0] PW_CNT   = CW'(PW);
  localparam logic [CW-1:0] LAT_CNT  = CW'(ARR_LAT);
  localparam logic [CW-1:0] LAST_CNT = CW'(PW + ARR_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     next_count;
  logic [WIDTH-1:0]  yreg_r;
  logic              ysign_r;
  logic [PW-1:0]     preg_r;

  // y_ser is registered, so each SHIFT cycle prepares the bit for the following counter value
  assign next_count = count_r + CW'(1);

  // Handshake sequencing, y serialisation and product deserialisation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      arr_clr   <= 1'b0;
      y_ser     <= 1'b0;
      arr_x     <= {WIDTH{1'b0}};
      out_p     <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
      yreg_r    <= {WIDTH{1'b0}};
      ysign_r   <= 1'b0;
      preg_r    <= {PW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            arr_x    <= in_x;
            yreg_r   <= in_y;
            ysign_r  <= in_y[WIDTH-1];
            in_ready <= 1'b0;
            arr_clr  <= 1'b1;
            y_ser    <= 1'b0;
            state_r  <= CLEAR;
          end
        end
        CLEAR: begin
          arr_clr <= 1'b0;
          count_r <= {CW{1'b0}};
          y_ser   <= yreg_r[0];
          yreg_r  <= {1'b0, yreg_r[WIDTH-1:1]};
          state_r <= SHIFT;
        end
        SHIFT: begin
          if (count_r >= LAT_CNT) begin
            preg_r <= {p_ser, preg_r[PW-1:1]};
          end
          if (next_count < W_CNT) begin
            y_ser  <= yreg_r[0];
            yreg_r <= {1'b0, yreg_r[WIDTH-1:1]};
          end else if (next_count < PW_CNT) begin
            y_ser <= SIGNED ? ysign_r : 1'b0;
          end else begin
            y_ser <= 1'b0;
          end
          if (count_r == LAST_CNT) begin
            out_p     <= {p_ser, preg_r[PW-1:1]};
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            count_r <= next_count;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
